// File: rtl/ifetch_responder_if.sv
// rtl/ifetch_responder_if.sv - memory-side request/response bus of the instruction fetch responder
//
// Purpose: bundles the single-beat memory read bus used by ifetch_responder.
// Signals:
//   m_req     master->slave  request valid (held until m_ack)
//   m_addr    master->slave  32-bit word address, bits [1:0] always 0
//   m_ack     slave->master  request accepted this cycle
//   m_rvalid  slave->master  read data valid (may coincide with m_ack)
//   m_rdata   slave->master  32-bit read data
// Modports: master (fetch responder side), slave (memory side).

interface ifetch_responder_if;
   logic        m_req;
   logic [31:0] m_addr;
   logic        m_ack;
   logic        m_rvalid;
   logic [31:0] m_rdata;

   modport master (
      output m_req,
      output m_addr,
      input  m_ack,
      input  m_rvalid,
      input  m_rdata
   );

   modport slave (
      input  m_req,
      input  m_addr,
      output m_ack,
      output m_rvalid,
      output m_rdata
   );
endinterface

// File: rtl/ifetch_responder.sv
// rtl/ifetch_responder.sv - instruction fetch responder between the PC stage and a single-beat memory
//
// Purpose: accepts one fetch at a time from the PC stage, issues at most one
// outstanding memory read, and returns the instruction word with a stall
// indication. Flushes cancel the fetch in flight; a beat already accepted by
// memory is drained and dropped in DISCARD.
// Ports:
//   clk      sole clock, rising edge
//   rst      synchronous active-high reset
//   i_en     fetch request valid
//   i_addr   fetch byte address
//   flush    pipeline flush, cancels the current fetch
//   i_rdata  instruction word, valid when i_en=1 and i_stall=0
//   i_stall  fetch not complete this cycle
//   mem      memory bus (ifetch_responder_if.master)
// Configuration: define IFETCH_LASTHIT_EN to add a one-entry last-fetch hit
// buffer that answers a repeated address in the same cycle.

module ifetch_responder (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_en,
   input  logic [31:0] i_addr,
   input  logic        flush,
   output logic [31:0] i_rdata,
   output logic        i_stall,
   ifetch_responder_if.master mem
);

   typedef enum logic [2:0] {IDLE, REQ, WAIT, DISCARD, RESP} state_t;

   state_t      state, state_nx;
   logic [31:0] areg, areg_nx;
   logic [31:0] dreg, dreg_nx;
   logic [31:0] rdata_q;
   logic        hit;
   logic [31:0] hit_data;

`ifdef IFETCH_LASTHIT_EN
   logic [31:0] lastaddr;
   logic [31:0] lastdata;
   logic        lastvalid;

   // Only aligned addresses are ever stored, so equality implies alignment.
   assign hit      = (state == IDLE) && i_en && !flush && lastvalid && (i_addr == lastaddr);
   assign hit_data = lastdata;

   // Capture on the edge that enters RESP from a memory state, so the buffer
   // holds exactly what RESP presents; misaligned responses come from IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         lastaddr  <= '0;
         lastdata  <= '0;
         lastvalid <= 1'b0;
      end else if (flush) begin
         lastvalid <= 1'b0;
      end else if ((state == REQ || state == WAIT) && state_nx == RESP) begin
         lastaddr  <= areg;
         lastdata  <= dreg_nx;
         lastvalid <= 1'b1;
      end
   end
`else
   assign hit      = 1'b0;
   assign hit_data = '0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         areg    <= '0;
         dreg    <= '0;
         rdata_q <= '0;
      end else begin
         state <= state_nx;
         areg  <= areg_nx;
         dreg  <= dreg_nx;
         // Remember the last word driven so i_rdata holds between responses.
         if (state == RESP) begin
            rdata_q <= dreg;
         end else if (hit) begin
            rdata_q <= hit_data;
         end
      end
   end

   always_comb begin
      state_nx = state;
      areg_nx  = areg;
      dreg_nx  = dreg;
      case (state)
         IDLE: begin
            if (i_en && !flush && !hit) begin
               if (i_addr[1:0] != 2'b00) begin
                  dreg_nx  = '0;
                  state_nx = RESP;
               end else begin
                  areg_nx  = i_addr;
                  state_nx = REQ;
               end
            end
         end
         REQ: begin
            if (mem.m_ack) begin
               if (mem.m_rvalid) begin
                  if (flush) begin
                     state_nx = IDLE;
                  end else begin
                     dreg_nx  = mem.m_rdata;
                     state_nx = RESP;
                  end
               end else begin
                  state_nx = flush ? DISCARD : WAIT;
               end
            end else if (flush) begin
               state_nx = IDLE;
            end
         end
         WAIT: begin
            // A beat arriving together with the flush is the one DISCARD
            // would wait for, so drop it here and skip DISCARD.
            if (mem.m_rvalid) begin
               if (flush) begin
                  state_nx = IDLE;
               end else begin
                  dreg_nx  = mem.m_rdata;
                  state_nx = RESP;
               end
            end else if (flush) begin
               state_nx = DISCARD;
            end
         end
         DISCARD: begin
            if (mem.m_rvalid) begin
               state_nx = IDLE;
            end
         end
         RESP: begin
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   assign mem.m_req  = (state == REQ) && !rst;
   assign mem.m_addr = areg;

   always_comb begin
      i_stall = 1'b0;
      if (!rst && i_en && !flush && state != RESP && !hit) begin
         i_stall = 1'b1;
      end
   end

   always_comb begin
      i_rdata = rdata_q;
      if (rst) begin
         i_rdata = '0;
      end else if (state == RESP) begin
         i_rdata = dreg;
      end else if (hit) begin
         i_rdata = hit_data;
      end
   end

endmodule

// File: tb/tb_ifetch_responder.sv
// tb/tb_ifetch_responder.sv - scoreboard testbench for ifetch_responder

module tb_ifetch_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_en;
   logic [31:0] i_addr;
   logic        flush;
   logic [31:0] i_rdata;
   logic        i_stall;

   ifetch_responder_if mem_if();

   ifetch_responder dut (
      .clk     (clk),
      .rst     (rst),
      .i_en    (i_en),
      .i_addr  (i_addr),
      .flush   (flush),
      .i_rdata (i_rdata),
      .i_stall (i_stall),
      .mem     (mem_if.master)
   );

   always #5 clk = ~clk;

   int          checks   = 0;
   int          failures = 0;
   logic [31:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   // Every completed fetch seen on the fetch side must match the oldest expectation.
   always @(negedge clk) begin
      if (rst === 1'b0 && i_en === 1'b1 && i_stall === 1'b0 && flush === 1'b0) begin
         if (exp_q.size() == 0) begin
            check("unexpected_resp", 32'(exp_q.size()), 32'd1);
         end else begin
            check("resp_data", i_rdata, exp_q.pop_front());
         end
      end
   end

   // One fetch; memory acks at cycle ack_c and returns data at cycle rv_c
   // (cycle 1 = first cycle i_en is high; 0 = never).
   task automatic do_fetch(input logic [31:0] addr, input int ack_c, input int rv_c,
                           input logic [31:0] data, input int min_st, input int max_st,
                           input int exp_req, input string tag);
      logic [31:0] expd;
      int          stalls;
      int          reqs;
      int          c;
      bit          done;
      expd   = (addr[1:0] != 2'b00) ? 32'h0 : data;
      stalls = 0;
      reqs   = 0;
      c      = 1;
      done   = 1'b0;
      exp_q.push_back(expd);
      i_en   = 1'b1;
      i_addr = addr;
      while (!done && c <= 20) begin
         mem_if.m_ack    = (c == ack_c);
         mem_if.m_rvalid = (c == rv_c);
         mem_if.m_rdata  = (c == rv_c) ? data : $urandom;
         @(negedge clk);
         if (mem_if.m_req) begin
            reqs++;
            check({tag, "_maddr"}, mem_if.m_addr, {addr[31:2], 2'b00});
         end
         if (i_stall) stalls++;
         else done = 1'b1;
         next_cyc();
         c++;
      end
      if (!done) check({tag, "_timeout"}, 32'(stalls), 32'(max_st));
      i_en            = 1'b0;
      mem_if.m_ack    = 1'b0;
      mem_if.m_rvalid = 1'b0;
      check({tag, "_stalls_in_range"}, 32'(stalls >= min_st && stalls <= max_st), 32'd1);
      check({tag, "_mreq_cycles"}, 32'(reqs), 32'(exp_req));
      @(negedge clk);
      check({tag, "_hold"}, i_rdata, expd);
      next_cyc();
   endtask

   initial begin
      rst             = 1'b1;
      i_en            = 1'b1;
      i_addr          = 32'h0000_0100;
      flush           = 1'b0;
      mem_if.m_ack    = 1'b0;
      mem_if.m_rvalid = 1'b0;
      mem_if.m_rdata  = '0;

      // Reset dominates a pending request.
      next_cyc();
      next_cyc();
      @(negedge clk);
      check("rst_stall", 32'(i_stall), 32'd0);
      check("rst_mreq", 32'(mem_if.m_req), 32'd0);
      check("rst_rdata", i_rdata, 32'h0);
      check("rst_maddr", mem_if.m_addr, 32'h0);
      next_cyc();
      rst  = 1'b0;
      i_en = 1'b0;
      next_cyc();

      // Same-cycle ack+data, then delayed data through WAIT, then misaligned.
      do_fetch(32'hBFC0_0000, 2, 2, 32'h3C1D_0001, 2, 2, 1, "boot");
      do_fetch(32'h0000_0400, 2, 5, 32'h8FBF_0010, 5, 5, 1, "wait");
      do_fetch(32'h0000_0402, 0, 0, 32'hAAAA_5555, 1, 2, 0, "misal");

      // Flush while REQ is unacknowledged withdraws the request.
      i_en   = 1'b1;
      i_addr = 32'h0000_2000;
      @(negedge clk);
      check("fr_c1_stall", 32'(i_stall), 32'd1);
      next_cyc();
      flush = 1'b1;
      @(negedge clk);
      check("fr_c2_mreq", 32'(mem_if.m_req), 32'd1);
      next_cyc();
      flush = 1'b0;
      i_en  = 1'b0;
      @(negedge clk);
      check("fr_withdrawn", 32'(mem_if.m_req), 32'd0);
      next_cyc();

      // Flush in WAIT: the later beat is dropped and never presented.
      i_en   = 1'b1;
      i_addr = 32'h0000_0800;
      next_cyc();
      mem_if.m_ack = 1'b1;
      next_cyc();
      mem_if.m_ack = 1'b0;
      next_cyc();
      flush = 1'b1;
      next_cyc();
      flush = 1'b0;
      @(negedge clk);
      check("disc_stall", 32'(i_stall), 32'd1);
      next_cyc();
      mem_if.m_rvalid = 1'b1;
      mem_if.m_rdata  = 32'hDEAD_BEEF;
      @(negedge clk);
      check("disc_beat_stall", 32'(i_stall), 32'd1);
      check("disc_beat_mreq", 32'(mem_if.m_req), 32'd0);
      next_cyc();
      mem_if.m_rvalid = 1'b0;
      i_en            = 1'b0;
      @(negedge clk);
      check("disc_not_presented", i_rdata, 32'h0);
      next_cyc();
      do_fetch(32'h8000_0180, 2, 2, 32'h2408_0005, 2, 2, 1, "after_flush");

`ifdef IFETCH_LASTHIT_EN
      do_fetch(32'h0000_1000, 2, 2, 32'h1234_5678, 2, 2, 1, "lh_miss");
      do_fetch(32'h0000_1000, 2, 2, 32'h1234_5678, 0, 0, 0, "lh_hit");
      flush = 1'b1;
      next_cyc();
      flush = 1'b0;
      do_fetch(32'h0000_1000, 2, 2, 32'h0BAD_F00D, 2, 2, 1, "lh_after_flush");
`else
      do_fetch(32'h0000_1000, 2, 2, 32'h1234_5678, 2, 2, 1, "nolh_first");
      do_fetch(32'h0000_1000, 2, 2, 32'h0BAD_F00D, 2, 2, 1, "nolh_second");
`endif

      // Reset in WAIT abandons the read; a late beat in IDLE is ignored.
      i_en   = 1'b1;
      i_addr = 32'h0000_3000;
      next_cyc();
      mem_if.m_ack = 1'b1;
      next_cyc();
      mem_if.m_ack = 1'b0;
      i_en         = 1'b0;
      next_cyc();
      rst = 1'b1;
      @(negedge clk);
      check("wrst_rdata", i_rdata, 32'h0);
      check("wrst_mreq", 32'(mem_if.m_req), 32'd0);
      next_cyc();
      rst             = 1'b0;
      mem_if.m_rvalid = 1'b1;
      mem_if.m_rdata  = 32'h1111_1111;
      @(negedge clk);
      check("late_beat_rdata", i_rdata, 32'h0);
      next_cyc();
      mem_if.m_rvalid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("post_rst_rdata", i_rdata, 32'h0);
         check("post_rst_mreq", 32'(mem_if.m_req), 32'd0);
         next_cyc();
      end
      do_fetch(32'h0000_3004, 2, 3, 32'h0000_0021, 3, 3, 1, "post_rst");

      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
